// File: rtl/maindec_if.sv
// maindec_if: opcode-in / control-out bundle for the main decoder
// slave modport faces the decoder, master modport faces the driver of op/clr_err
interface maindec_if;
  logic [6:0] op;
  logic       clr_err;
  logic [1:0] ResultSrc;
  logic       MemWrite;
  logic       Branch;
  logic       ALUSrc;
  logic       RegWrite;
  logic       Jump;
  logic [2:0] ImmSrc;
  logic [1:0] ALUOp;
  logic       Illegal;
  logic       ErrSticky;
  modport slave (
    input  op, clr_err,
    output ResultSrc, MemWrite, Branch, ALUSrc, RegWrite, Jump, ImmSrc, ALUOp, Illegal, ErrSticky
  );
  modport master (
    output op, clr_err,
    input  ResultSrc, MemWrite, Branch, ALUSrc, RegWrite, Jump, ImmSrc, ALUOp, Illegal, ErrSticky
  );
endinterface

// File: rtl/maindec.sv
// maindec: RISC-V main decoder, combinational controls from op plus a sticky illegal-op flag
// Ports: clk, reset (sync active-high, clears ErrSticky only); bus (maindec_if.slave):
//   op/clr_err in; ResultSrc, MemWrite, Branch, ALUSrc, RegWrite, Jump, ImmSrc, ALUOp, Illegal, ErrSticky out.
// Macro MAINDEC_EXT_OPS_EN adds I-ALU, jalr and lui decoding; otherwise they decode as illegal.
module maindec (
  input logic       clk,
  input logic       reset,
  maindec_if.slave  bus
);
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
`ifdef MAINDEC_EXT_OPS_EN
  localparam logic [6:0] OP_IALU = 7'b0010011;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
`endif
  // ctrl = {RegWrite, ImmSrc[2:0], ALUSrc, MemWrite, ResultSrc[1:0], Branch, ALUOp[1:0], Jump}
  logic [11:0] ctrl;
  logic        ill;
  logic        err_d, err_q;
  always_comb begin
    ctrl = '0;
    ill  = 1'b0;
    case (bus.op)
      OP_LW:   ctrl = {1'b1, 3'b000, 1'b1, 1'b0, 2'b01, 1'b0, 2'b00, 1'b0};
      OP_SW:   ctrl = {1'b0, 3'b001, 1'b1, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0};
      OP_R:    ctrl = {1'b1, 3'b000, 1'b0, 1'b0, 2'b00, 1'b0, 2'b10, 1'b0};
      OP_BEQ:  ctrl = {1'b0, 3'b010, 1'b0, 1'b0, 2'b00, 1'b1, 2'b01, 1'b0};
      OP_JAL:  ctrl = {1'b1, 3'b011, 1'b0, 1'b0, 2'b10, 1'b0, 2'b00, 1'b1};
`ifdef MAINDEC_EXT_OPS_EN
      OP_IALU: ctrl = {1'b1, 3'b000, 1'b1, 1'b0, 2'b00, 1'b0, 2'b10, 1'b0};
      OP_JALR: ctrl = {1'b1, 3'b000, 1'b1, 1'b0, 2'b10, 1'b0, 2'b00, 1'b1};
      OP_LUI:  ctrl = {1'b1, 3'b100, 1'b0, 1'b0, 2'b11, 1'b0, 2'b00, 1'b0};
`endif
      default: ill  = 1'b1;
    endcase
  end
  assign {bus.RegWrite, bus.ImmSrc, bus.ALUSrc, bus.MemWrite, bus.ResultSrc,
          bus.Branch, bus.ALUOp, bus.Jump} = ctrl;
  assign bus.Illegal = ill;
  // clear beats set, so an illegal op coincident with clr_err is lost until it recurs
  assign err_d = bus.clr_err ? 1'b0 : (ill ? 1'b1 : err_q);
  always_ff @(posedge clk)
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  assign bus.ErrSticky = err_q;
endmodule

// File: tb/tb_maindec.sv
// tb_maindec: randomized and directed self-checking bench for maindec
module tb_maindec;
  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;
  logic exp_s = 1'b0;
  logic [6:0] legal [8] = '{7'h03, 7'h23, 7'h33, 7'h63, 7'h6F, 7'h13, 7'h67, 7'h37};
  maindec_if bus ();
  maindec dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
`ifdef MAINDEC_EXT_OPS_EN
  localparam bit EXT = 1'b1;
`else
  localparam bit EXT = 1'b0;
`endif
  // {Illegal, ResultSrc, MemWrite, Branch, ALUSrc, RegWrite, Jump, ImmSrc, ALUOp}
  function automatic logic [12:0] obs();
    return {bus.Illegal, bus.ResultSrc, bus.MemWrite, bus.Branch, bus.ALUSrc,
            bus.RegWrite, bus.Jump, bus.ImmSrc, bus.ALUOp};
  endfunction
  function automatic logic [12:0] model(input logic [6:0] op);
    logic [1:0] rs = 0, ao = 0;
    logic [2:0] imm = 0;
    logic mw = 0, br = 0, as = 0, rw = 0, j = 0, il = 0;
    if (op == 7'h03) begin rw = 1; as = 1; rs = 1; end
    else if (op == 7'h23) begin mw = 1; as = 1; imm = 1; end
    else if (op == 7'h33) begin rw = 1; ao = 2; end
    else if (op == 7'h63) begin br = 1; imm = 2; ao = 1; end
    else if (op == 7'h6F) begin rw = 1; j = 1; imm = 3; rs = 2; end
    else if (EXT && op == 7'h13) begin rw = 1; as = 1; ao = 2; end
    else if (EXT && op == 7'h67) begin rw = 1; as = 1; j = 1; rs = 2; end
    else if (EXT && op == 7'h37) begin rw = 1; imm = 4; rs = 3; end
    else il = 1;
    return {il, rs, mw, br, as, rw, j, imm, ao};
  endfunction
  task automatic apply(input logic [6:0] op, input logic clr, input logic rst);
    @(negedge clk);
    bus.op = op;
    bus.clr_err = clr;
    reset = rst;
    #1;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    exp_s = reset ? 1'b0 : (bus.clr_err ? 1'b0 : (model(bus.op)[12] ? 1'b1 : exp_s));
  endtask
  task automatic test_reset();
    apply(7'h6F, 1'b0, 1'b1);
    n_cmp++;
    if (obs() !== model(7'h6F)) begin n_err++; $display("FAIL reset_comb got=%h exp=%h", obs(), model(7'h6F)); end
    tick();
    n_cmp++;
    if (bus.ErrSticky !== 1'b0) begin n_err++; $display("FAIL reset_sticky got=%b exp=0", bus.ErrSticky); end
  endtask
  task automatic test_decode();
    logic [6:0] ops [11] = '{7'h03, 7'h23, 7'h33, 7'h63, 7'h6F, 7'h13, 7'h67, 7'h37, 7'h7F, 7'h00, 7'h73};
    foreach (ops[i]) begin
      apply(ops[i], 1'b1, 1'b0);
      n_cmp++;
      if (obs() !== model(ops[i])) begin n_err++; $display("FAIL decode op=%b got=%h exp=%h", ops[i], obs(), model(ops[i])); end
      tick();
    end
    apply(7'h37, 1'b0, 1'b0);
    n_cmp++;
    if (EXT ? (bus.ResultSrc !== 2'b11 || bus.Illegal !== 1'b0) : (bus.Illegal !== 1'b1))
      begin n_err++; $display("FAIL lui ResultSrc=%b Illegal=%b ext=%0d", bus.ResultSrc, bus.Illegal, EXT); end
    tick();
  endtask
  task automatic test_sticky();
    apply(7'h03, 1'b1, 1'b0);
    tick();
    apply(7'h7F, 1'b0, 1'b0);
    n_cmp++;
    if (obs() !== 13'h1000) begin n_err++; $display("FAIL illegal_comb got=%h exp=1000", obs()); end
    tick();
    n_cmp++;
    if (bus.ErrSticky !== 1'b1) begin n_err++; $display("FAIL sticky_set got=%b exp=1", bus.ErrSticky); end
    apply(7'h03, 1'b0, 1'b0);
    tick();
    n_cmp++;
    if (bus.ErrSticky !== 1'b1) begin n_err++; $display("FAIL sticky_hold got=%b exp=1", bus.ErrSticky); end
    apply(7'h03, 1'b1, 1'b0);
    tick();
    n_cmp++;
    if (bus.ErrSticky !== 1'b0) begin n_err++; $display("FAIL sticky_clr got=%b exp=0", bus.ErrSticky); end
    apply(7'h03, 1'b0, 1'b1);
    tick();
    n_cmp++;
    if (bus.ErrSticky !== 1'b0) begin n_err++; $display("FAIL sticky_reset got=%b exp=0", bus.ErrSticky); end
  endtask
  task automatic test_clr_vs_illegal();
    apply(7'h7F, 1'b0, 1'b0);
    tick();
    apply(7'h7F, 1'b1, 1'b0);
    tick();
    n_cmp++;
    if (bus.ErrSticky !== 1'b0) begin n_err++; $display("FAIL clr_wins got=%b exp=0", bus.ErrSticky); end
    apply(7'h7F, 1'b0, 1'b0);
    tick();
    n_cmp++;
    if (bus.ErrSticky !== 1'b1) begin n_err++; $display("FAIL reset_again got=%b exp=1", bus.ErrSticky); end
    apply(7'h7F, 1'b0, 1'b1);
    n_cmp++;
    if (bus.Illegal !== 1'b1) begin n_err++; $display("FAIL comb_in_reset got=%b exp=1", bus.Illegal); end
    tick();
    n_cmp++;
    if (bus.ErrSticky !== 1'b0) begin n_err++; $display("FAIL reset_over_illegal got=%b exp=0", bus.ErrSticky); end
  endtask
  task automatic test_random();
    logic [6:0] op;
    for (int i = 0; i < 300; i++) begin
      op = ($urandom_range(0, 1) == 1) ? legal[$urandom_range(0, 7)] : 7'($urandom);
      apply(op, $urandom_range(0, 5) == 0, $urandom_range(0, 31) == 0);
      n_cmp++;
      if (obs() !== model(op)) begin n_err++; $display("FAIL rand_comb op=%b got=%h exp=%h", op, obs(), model(op)); end
      tick();
      n_cmp++;
      if (bus.ErrSticky !== exp_s) begin n_err++; $display("FAIL rand_sticky op=%b got=%b exp=%b", op, bus.ErrSticky, exp_s); end
    end
  endtask
  initial begin
    reset = 1'b1;
    bus.op = 7'h03;
    bus.clr_err = 1'b0;
    test_reset();
    test_decode();
    test_sticky();
    test_clr_vs_illegal();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/maindec.md
MAINDEC -- requirements
Module: maindec

Interface
REQ-001 The block SHALL have no parameters; all options are set by the configuration macro in REQ-021.
REQ-002 The block SHALL have one clock, and reset SHALL be synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for the status register.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 op  input  7  instruction opcode field, bits [6:0].
REQ-006 clr_err  input  1  synchronous clear of ErrSticky.
REQ-007 ResultSrc  output  2  writeback select: 00 ALU, 01 memory, 10 PC+4, 11 immediate.
REQ-008 MemWrite, Branch, ALUSrc, RegWrite, Jump  output  1 each  datapath controls.
REQ-009 ImmSrc  output  3  immediate format: 000 I, 001 S, 010 B, 011 J, 100 U.
REQ-010 ALUOp  output  2  ALU class: 00 add, 01 subtract/compare, 10 funct-decoded.
REQ-011 Illegal  output  1  current op is not a supported opcode.
REQ-012 ErrSticky  output  1  registered flag meaning an illegal op was seen since the last clear.

Function
REQ-013 All outputs except ErrSticky SHALL be purely combinational from op, with zero latency.
REQ-014 Each opcode SHALL decode to exactly the fields below; every field not listed SHALL be 0.
- lw 0000011: RegWrite=1, ALUSrc=1, ResultSrc=01, ImmSrc=000, ALUOp=00.
- sw 0100011: MemWrite=1, ALUSrc=1, ImmSrc=001, ALUOp=00.
- R-type 0110011: RegWrite=1, ALUSrc=0, ALUOp=10, ResultSrc=00.
- beq 1100011: Branch=1, ALUSrc=0, ImmSrc=010, ALUOp=01.
- jal 1101111: RegWrite=1, Jump=1, ImmSrc=011, ResultSrc=10.
REQ-015 Extended opcodes, available only when MAINDEC_EXT_OPS_EN is defined, SHALL decode as follows.
- I-ALU 0010011: RegWrite=1, ALUSrc=1, ImmSrc=000, ALUOp=10.
- jalr 1100111: RegWrite=1, ALUSrc=1, Jump=1, ImmSrc=000, ResultSrc=10.
- lui 0110111: RegWrite=1, ImmSrc=100, ResultSrc=11.
REQ-016 Any other op SHALL drive all control outputs to 0 and Illegal=1.
REQ-017 For every supported op, Illegal SHALL be 0.
REQ-018 ErrSticky update on each rising clk edge, in priority order:
- reset: ErrSticky <= 0.
- else clr_err: ErrSticky <= 0.
- else Illegal: ErrSticky <= 1.
- else: hold.
REQ-019 clr_err and Illegal asserted in the same cycle SHALL clear ErrSticky; an Illegal still present the following cycle sets it again.

Reset
REQ-020 Reset SHALL affect only ErrSticky, which reads 0 on the cycle after a reset edge.
- Combinational outputs follow op even while reset is asserted.

Configuration
REQ-021 MAINDEC_EXT_OPS_EN, when defined, SHALL enable decoding of I-ALU, jalr and lui per REQ-015.
- When undefined, those three opcodes SHALL decode as illegal per REQ-016.

Verification
REQ-022 op=0000011 -> RegWrite=1, ALUSrc=1, ResultSrc=01, MemWrite=0, Illegal=0.
REQ-023 op=0100011 -> MemWrite=1, ALUSrc=1, RegWrite=0, ImmSrc=001.
REQ-024 op=0110011 -> RegWrite=1, ALUSrc=0, ALUOp=10; then op=1100011 -> Branch=1, ALUOp=01, ImmSrc=010.
REQ-025 op=1101111 -> Jump=1, ResultSrc=10, ImmSrc=011.
- op=0110111 -> ResultSrc=11 with MAINDEC_EXT_OPS_EN defined, Illegal=1 without it.
REQ-026 op=1111111 for one cycle -> Illegal=1, all controls 0, ErrSticky=1 after the edge and held.
- Then clr_err=1 for one cycle -> ErrSticky=0.
- Then reset=1 -> ErrSticky remains 0.
